axis_gate_sequencer: RTL and testbench

// Plays a table of 128-bit gate descriptors {poff, total, stop, start} into the AXI4-Stream slave of

---
 rtl/axis_gate_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_axis_gate_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_gate_sequencer.sv
// -----------------------------------------------------------------------------
// axis_gate_sequencer
//
// Replays a table of 128-bit gate descriptors {poff, total, stop, start} onto an
// AXI4-Stream master, one word per gate. The table is a write-only RAM loaded
// from the config bus. A start replays entries 0..last_addr either `repeats`
// times or forever (repeats == 0), so the gate schedule runs without any
// per-gate CPU writes.
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   cfg_wren/addr/data        table write port (usable in every state)
//   last_addr, repeats        pass length and pass count, sampled on start
//   start, stop               begin playback (IDLE only) / abort playback
//   m_axis_tdata/tvalid/tready  descriptor stream
//   busy                      high whenever the sequencer is not IDLE
//   done                      one-cycle pulse on the IDLE entry after the final pass
//   index                     table index of the word being fetched/presented
//
// Handshake: a word transfers on a cycle where m_axis_tvalid & m_axis_tready
// are both high. Once tvalid rises, tdata is held bit-stable and tvalid stays
// high until that transfer happens; only reset can withdraw it.
// -----------------------------------------------------------------------------
module axis_gate_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_wren,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [127:0]          cfg_data,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [31:0]           repeats,
  input  logic                  start,
  input  logic                  stop,
  output logic [127:0]          m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] index
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t state;
  state_t state_nxt;

  logic [127:0]          mem [DEPTH];
  logic [127:0]          rd_data;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [31:0]           rep_q;
  logic [31:0]           pass_q;
  logic                  stop_seen;

  // Decoded control strobes (output comb).
  logic        launch;      // start accepted in IDLE
  logic        hs;          // handshake in VALID
  logic        abort_hs;    // handshake with a pending stop
  logic        last_word;   // presented word is the last of the pass
  logic [31:0] pass_inc;
  logic        final_pass;

  // ---------------------------------------------------------------------------
  // Table RAM: one write port, registered read. Both sides use non-blocking
  // updates, so a same-address write and read on one edge returns the old word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (cfg_wren) begin
      mem[cfg_addr] <= cfg_data;
    end
    if (state == S_FETCH) begin
      rd_data <= mem[index];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_FETCH;
      S_FETCH: state_nxt = stop ? S_IDLE : S_LOAD;
      // No word has been issued yet, so stop can still drop straight to IDLE.
      S_LOAD:  state_nxt = stop ? S_IDLE : S_VALID;
      S_VALID: begin
        if (hs) begin
          if (abort_hs)                      state_nxt = S_IDLE;
          else if (last_word && final_pass)  state_nxt = S_IDLE;
          else                               state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state != S_IDLE);
    launch     = (state == S_IDLE) && start && !stop;
    hs         = (state == S_VALID) && m_axis_tvalid && m_axis_tready;
    // A stop arriving on the handshake cycle itself counts as seen.
    abort_hs   = hs && (stop_seen || stop);
    last_word  = (index == last_q);
    pass_inc   = pass_q + 32'd1;
    final_pass = (rep_q != 32'd0) && (pass_inc == rep_q);
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      done          <= 1'b0;
      index         <= '0;
      pass_q        <= '0;
      last_q        <= '0;
      rep_q         <= '0;
      stop_seen     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            last_q    <= last_addr;
            rep_q     <= repeats;
            index     <= '0;
            pass_q    <= '0;
            stop_seen <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!stop) begin
            m_axis_tdata  <= rd_data;
            m_axis_tvalid <= 1'b1;
          end
        end
        S_VALID: begin
          if (stop) begin
            stop_seen <= 1'b1;
          end
          if (hs) begin
            m_axis_tvalid <= 1'b0;
            if (!abort_hs) begin
              if (!last_word) begin
                index <= index + 1'b1;
              end else begin
                // pass_q wraps silently in infinite mode.
                pass_q <= pass_inc;
                if (final_pass) begin
                  done <= 1'b1;
                end else begin
                  index <= '0;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_gate_sequencer.sv
module tb_axis_gate_sequencer;

  localparam int AW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_wren;
  logic [AW-1:0] cfg_addr;
  logic [127:0]  cfg_data;
  logic [AW-1:0] last_addr;
  logic [31:0]   repeats;
  logic          start;
  logic          stop;
  logic [127:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;
  logic          done;
  logic [AW-1:0] index;

  always #5 aclk = ~aclk;

  axis_gate_sequencer #(.ADDR_WIDTH(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_wren      (cfg_wren),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .last_addr     (last_addr),
    .repeats       (repeats),
    .start         (start),
    .stop          (stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .index         (index)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [127:0] model_mem [256];
  logic [127:0] exp_q[$];
  logic [AW-1:0] exp_idx_q[$];

  typedef struct {
    logic          start;
    logic          exp_tvalid;
    logic          exp_busy;
    logic          exp_done;
    logic [AW-1:0] exp_index;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] gate_word(input int i);
    gate_word = {32'(i), 32'(100 + i), 32'd50, 32'd10};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end just after a negedge)
  // ---------------------------------------------------------------------------
  task automatic write_entry(input logic [AW-1:0] a, input logic [127:0] d);
    cfg_wren = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    model_mem[a] = d;
    @(negedge aclk);
    cfg_wren = 1'b0;
  endtask

  task automatic wait_tvalid(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (m_axis_tvalid) break;
      @(negedge aclk);
    end
    check($sformatf("%s_tvalid_timeout", name), m_axis_tvalid, 1'b1);
  endtask

  // Full playback with tready held high; optionally rewrites entry 1 on the
  // same edge that fetches it in the first pass (old word now, new next pass).
  task automatic run_play(input string name, input logic [AW-1:0] la, input logic [31:0] reps,
                          input bit inject, input logic [127:0] new_word);
    int  last_ev;
    int  cyc;
    bit  finished;
    bit  injected;
    logic [127:0] w;
    logic [AW-1:0] wi;
    exp_q.delete();
    exp_idx_q.delete();
    for (int p = 0; p < int'(reps); p++) begin
      for (int i = 0; i <= int'(la); i++) begin
        exp_q.push_back((inject && p >= 1 && i == 1) ? new_word : model_mem[i]);
        exp_idx_q.push_back(AW'(i));
      end
    end
    last_addr     = la;
    repeats       = reps;
    m_axis_tready = 1'b1;
    start         = 1'b1;
    last_ev  = 0;
    finished = 1'b0;
    injected = 1'b0;
    for (cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge aclk);
      start    = 1'b0;
      cfg_wren = 1'b0;
      if (done) begin
        check($sformatf("%s_done_after_last", name), 128'(exp_q.size()), 128'd0);
        check($sformatf("%s_busy_at_done", name), busy, 1'b0);
        finished = 1'b1;
      end else if (m_axis_tvalid) begin
        check($sformatf("%s_gap_c%0d", name, cyc), 128'(cyc - last_ev), 128'd3);
        if (exp_q.size() == 0) begin
          check($sformatf("%s_extra_word", name), m_axis_tvalid, 1'b0);
        end else begin
          w  = exp_q.pop_front();
          wi = exp_idx_q.pop_front();
          check($sformatf("%s_tdata_c%0d", name, cyc), m_axis_tdata, w);
          check($sformatf("%s_index_c%0d", name, cyc), 128'(index), 128'(wi));
        end
        last_ev = cyc;
      end else if (inject && !injected && busy && index == AW'(1)) begin
        cfg_wren = 1'b1;
        cfg_addr = AW'(1);
        cfg_data = new_word;
        model_mem[1] = new_word;
        injected = 1'b1;
      end
    end
    check($sformatf("%s_done_seen", name), finished, 1'b1);
    @(negedge aclk);
    check($sformatf("%s_done_one_cycle", name), done, 1'b0);
    check($sformatf("%s_idle_after", name), busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    aresetn = 1'b0;
    cfg_wren = 1'b0; cfg_addr = '0; cfg_data = '0;
    last_addr = '0; repeats = '0;
    start = 1'b0; stop = 1'b0; m_axis_tready = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 'x;

    // Cycle table for a single pass of 3 words, tready high throughout.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

    // Reset state
    #12;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata",  m_axis_tdata,  128'd0);
    check("rst_busy",   busy,          1'b0);
    check("rst_done",   done,          1'b0);
    check("rst_index",  128'(index),   128'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 3; i++) write_entry(AW'(i), gate_word(i));
    write_entry(AW'(3), gate_word(3));

    // Single pass, cycle by cycle
    last_addr = AW'(2);
    repeats = 32'd1;
    m_axis_tready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      check($sformatf("t1_tvalid_v%0d", v), m_axis_tvalid, vecs[v].exp_tvalid);
      check($sformatf("t1_busy_v%0d", v),   busy,          vecs[v].exp_busy);
      check($sformatf("t1_done_v%0d", v),   done,          vecs[v].exp_done);
      check($sformatf("t1_index_v%0d", v),  128'(index),   128'(vecs[v].exp_index));
      if (vecs[v].exp_tvalid)
        check($sformatf("t1_tdata_v%0d", v), m_axis_tdata, model_mem[vecs[v].exp_index]);
      start = vecs[v].start;
      @(negedge aclk);
    end
    start = 1'b0;

    // Two passes
    run_play("t2", AW'(2), 32'd2, 1'b0, '0);

    // Backpressure, start while busy, sticky stop (infinite mode)
    last_addr = AW'(2);
    repeats = 32'd0;
    m_axis_tready = 1'b0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_tvalid("t3", 10);
    for (int k = 0; k < 10; k++) begin
      start = (k >= 3 && k < 6);
      check($sformatf("t3_hold_tvalid_%0d", k), m_axis_tvalid, 1'b1);
      check($sformatf("t3_hold_tdata_%0d", k),  m_axis_tdata,  model_mem[0]);
      check($sformatf("t3_hold_index_%0d", k),  128'(index),   128'd0);
      @(negedge aclk);
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    check("t3_after_hs_tvalid", m_axis_tvalid, 1'b0);
    check("t3_after_hs_index",  128'(index),   128'd1);
    wait_tvalid("t3b", 10);
    check("t3_word1_tdata", m_axis_tdata, model_mem[1]);
    check("t3_word1_index", 128'(index),  128'd1);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_stop_hold_tvalid_%0d", k), m_axis_tvalid, 1'b1);
      check($sformatf("t4_stop_hold_tdata_%0d", k),  m_axis_tdata,  model_mem[1]);
      @(negedge aclk);
    end
    m_axis_tready = 1'b1;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    check("t4_stop_busy",   busy,          1'b0);
    check("t4_stop_tvalid", m_axis_tvalid, 1'b0);
    check("t4_stop_done",   done,          1'b0);
    @(negedge aclk);
    check("t4_stop_done2",  done,          1'b0);

    // start & stop together in IDLE; stop during FETCH
    repeats = 32'd1;
    m_axis_tready = 1'b1;
    start = 1'b1; stop = 1'b1;
    @(negedge aclk);
    check("t4_startstop_busy", busy, 1'b0);
    stop = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    check("t4_fetch_busy", busy, 1'b1);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    check("t4_fetchstop_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_fetchstop_tvalid_%0d", k), m_axis_tvalid, 1'b0);
      @(negedge aclk);
    end

    // Async reset mid-VALID, then replay from entry 0
    repeats = 32'd0;
    m_axis_tready = 1'b0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_tvalid("t5", 10);
    #2 aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 1'b0);
    check("t5_rst_busy",   busy,          1'b0);
    check("t5_rst_index",  128'(index),   128'd0);
    check("t5_rst_tdata",  m_axis_tdata,  128'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_play("t5_replay", AW'(2), 32'd1, 1'b0, '0);

    // Table write during playback: same-edge write is read-first, next pass sees it
    run_play("t6", AW'(2), 32'd2, 1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
